// File: rtl/point_update_sequencer.sv
// Initiator side of the point-update handshake: owns the soft-body point array and walks every
// point through an update_point responder once per frame. Optional watchdog: UPDATE_SEQ_TIMEOUT_EN.
module point_update_sequencer #(
    parameter int POSITION_SIZE  = 8,
    parameter int VELOCITY_SIZE  = 8,
    parameter int NUM_POINTS     = 4,
    parameter int IDX_W          = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     frame_start_in,
    input  logic                     load_valid_in,
    input  logic [IDX_W-1:0]         load_idx_in,
    input  logic [POSITION_SIZE-1:0] load_pos_x_in,
    input  logic [POSITION_SIZE-1:0] load_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0] load_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0] load_vel_y_in,
    input  logic [IDX_W-1:0]         rd_idx_in,
    output logic [POSITION_SIZE-1:0] rd_pos_x_out,
    output logic [POSITION_SIZE-1:0] rd_pos_y_out,
    output logic [VELOCITY_SIZE-1:0] rd_vel_x_out,
    output logic [VELOCITY_SIZE-1:0] rd_vel_y_out,
    output logic                     begin_out,
    output logic [POSITION_SIZE-1:0] pos_x_out,
    output logic [POSITION_SIZE-1:0] pos_y_out,
    output logic [VELOCITY_SIZE-1:0] vel_x_out,
    output logic [VELOCITY_SIZE-1:0] vel_y_out,
    input  logic [POSITION_SIZE-1:0] new_pos_x_in,
    input  logic [POSITION_SIZE-1:0] new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0] new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0] new_vel_y_in,
    input  logic                     result_in,
    output logic                     busy_out,
    output logic                     frame_done_out,
    output logic                     timeout_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    state_t                   state_r, state_s;
    logic [IDX_W-1:0]         idx_r, idx_s;
    logic                     load_ok_s, rd_ok_s, timeout_hit_s, fwd_s;
    logic                     wr_en_s;
    logic [IDX_W-1:0]         wr_idx_s;
    logic [POSITION_SIZE-1:0] wr_pos_x_s, wr_pos_y_s;
    logic [VELOCITY_SIZE-1:0] wr_vel_x_s, wr_vel_y_s;
    logic [POSITION_SIZE-1:0] issue_pos_x_s, issue_pos_y_s;
    logic [VELOCITY_SIZE-1:0] issue_vel_x_s, issue_vel_y_s;

    logic [POSITION_SIZE-1:0] pos_x_r [NUM_POINTS];
    logic [POSITION_SIZE-1:0] pos_y_r [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] vel_x_r [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] vel_y_r [NUM_POINTS];

    logic                     begin_r, busy_r, done_r;
    logic [POSITION_SIZE-1:0] pos_x_out_r, pos_y_out_r, rd_pos_x_r, rd_pos_y_r;
    logic [VELOCITY_SIZE-1:0] vel_x_out_r, vel_y_out_r, rd_vel_x_r, rd_vel_y_r;

    // An index bus that cannot express an out-of-range value needs no range check.
    if ((32'd1 << IDX_W) == NUM_POINTS) begin : g_full_range
        assign load_ok_s = 1'b1;
        assign rd_ok_s   = 1'b1;
    end else begin : g_partial_range
        localparam logic [IDX_W:0] NUM_PTS_L = (IDX_W + 1)'(NUM_POINTS);
        assign load_ok_s = ({1'b0, load_idx_in} < NUM_PTS_L);
        assign rd_ok_s   = ({1'b0, rd_idx_in} < NUM_PTS_L);
    end

    // Next-state, next-index and the single array write port (load in IDLE, result in WAIT).
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        wr_en_s    = 1'b0;
        wr_idx_s   = idx_r;
        wr_pos_x_s = new_pos_x_in;
        wr_pos_y_s = new_pos_y_in;
        wr_vel_x_s = new_vel_x_in;
        wr_vel_y_s = new_vel_y_in;
        case (state_r)
            IDLE: begin
                if (load_valid_in && load_ok_s) begin
                    wr_en_s    = 1'b1;
                    wr_idx_s   = load_idx_in;
                    wr_pos_x_s = load_pos_x_in;
                    wr_pos_y_s = load_pos_y_in;
                    wr_vel_x_s = load_vel_x_in;
                    wr_vel_y_s = load_vel_y_in;
                end else begin
                    wr_en_s = 1'b0;
                end
                if (frame_start_in) begin
                    state_s = ISSUE;
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (result_in || timeout_hit_s) begin
                    // A watchdog expiry advances exactly like a result but leaves the entry alone.
                    wr_en_s = result_in;
                    if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + IDX_W'(1'b1);
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // A load landing in the same cycle as frame start must be what point 0 issues with.
    assign fwd_s         = wr_en_s && (wr_idx_s == idx_s);
    assign issue_pos_x_s = fwd_s ? wr_pos_x_s : pos_x_r[idx_s];
    assign issue_pos_y_s = fwd_s ? wr_pos_y_s : pos_y_r[idx_s];
    assign issue_vel_x_s = fwd_s ? wr_vel_x_s : vel_x_r[idx_s];
    assign issue_vel_y_s = fwd_s ? wr_vel_y_s : vel_y_r[idx_s];

    // FSM state and point index registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Point storage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 32'sd0; i < NUM_POINTS; i++) begin
                pos_x_r[i] <= {POSITION_SIZE{1'b0}};
                pos_y_r[i] <= {POSITION_SIZE{1'b0}};
                vel_x_r[i] <= {VELOCITY_SIZE{1'b0}};
                vel_y_r[i] <= {VELOCITY_SIZE{1'b0}};
            end
        end else if (wr_en_s) begin
            pos_x_r[wr_idx_s] <= wr_pos_x_s;
            pos_y_r[wr_idx_s] <= wr_pos_y_s;
            vel_x_r[wr_idx_s] <= wr_vel_x_s;
            vel_y_r[wr_idx_s] <= wr_vel_y_s;
        end
    end

    // Responder request and frame status outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            begin_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pos_x_out_r <= {POSITION_SIZE{1'b0}};
            pos_y_out_r <= {POSITION_SIZE{1'b0}};
            vel_x_out_r <= {VELOCITY_SIZE{1'b0}};
            vel_y_out_r <= {VELOCITY_SIZE{1'b0}};
        end else begin
            begin_r <= (state_s == ISSUE);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            if (state_s == ISSUE) begin
                pos_x_out_r <= issue_pos_x_s;
                pos_y_out_r <= issue_pos_y_s;
                vel_x_out_r <= issue_vel_x_s;
                vel_y_out_r <= issue_vel_y_s;
            end
        end
    end

    // Render-path readout, one cycle behind rd_idx_in.
    always_ff @(posedge clk_in) begin
        if (rst_in || !rd_ok_s) begin
            rd_pos_x_r <= {POSITION_SIZE{1'b0}};
            rd_pos_y_r <= {POSITION_SIZE{1'b0}};
            rd_vel_x_r <= {VELOCITY_SIZE{1'b0}};
            rd_vel_y_r <= {VELOCITY_SIZE{1'b0}};
        end else begin
            rd_pos_x_r <= pos_x_r[rd_idx_in];
            rd_pos_y_r <= pos_y_r[rd_idx_in];
            rd_vel_x_r <= vel_x_r[rd_idx_in];
            rd_vel_y_r <= vel_y_r[rd_idx_in];
        end
    end

`ifdef UPDATE_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             timeout_r;

    assign timeout_hit_s = (state_r == WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_out   = timeout_r;

    // WAIT-cycle counter (zero on every entry to WAIT) and sticky timeout flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wait_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
            end else begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end
            timeout_r <= timeout_r | (timeout_hit_s & ~result_in);
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_out   = 1'b0;
`endif

    assign begin_out      = begin_r;
    assign busy_out       = busy_r;
    assign frame_done_out = done_r;
    assign pos_x_out      = pos_x_out_r;
    assign pos_y_out      = pos_y_out_r;
    assign vel_x_out      = vel_x_out_r;
    assign vel_y_out      = vel_y_out_r;
    assign rd_pos_x_out   = rd_pos_x_r;
    assign rd_pos_y_out   = rd_pos_y_r;
    assign rd_vel_x_out   = rd_vel_x_r;
    assign rd_vel_y_out   = rd_vel_y_r;

endmodule

// File: tb/tb_point_update_sequencer.sv
// Bench for point_update_sequencer: frame timeline model (cycle-indexed expectations derived from
// the issue/done timing rules) plus a point-array model, checked every cycle and on readback.
module tb_point_update_sequencer;

    localparam int NP   = 4;
    localparam int TO   = 8;
    localparam int MAXC = 4096;

    logic       clk_in = 1'b0;
    logic       rst_in, frame_start_in, load_valid_in;
    logic [1:0] load_idx_in, rd_idx_in;
    logic [7:0] load_pos_x_in, load_pos_y_in, load_vel_x_in, load_vel_y_in;
    logic [7:0] rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out;
    logic       begin_out, busy_out, frame_done_out, timeout_out, result_in;
    logic [7:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
    logic [7:0] new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in;

    logic       resp_v = 1'b0, spur_v = 1'b0, spur_idle_v = 1'b0;
    logic [7:0] resp_px, resp_py, resp_vx, resp_vy;

    assign result_in    = resp_v | spur_v | spur_idle_v;
    assign new_pos_x_in = resp_v ? resp_px : 8'hA5;
    assign new_pos_y_in = resp_v ? resp_py : 8'h5A;
    assign new_vel_x_in = resp_v ? resp_vx : 8'h3C;
    assign new_vel_y_in = resp_v ? resp_vy : 8'hC3;

    point_update_sequencer #(.NUM_POINTS(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .load_valid_in(load_valid_in), .load_idx_in(load_idx_in),
        .load_pos_x_in(load_pos_x_in), .load_pos_y_in(load_pos_y_in),
        .load_vel_x_in(load_vel_x_in), .load_vel_y_in(load_vel_y_in),
        .rd_idx_in(rd_idx_in), .rd_pos_x_out(rd_pos_x_out), .rd_pos_y_out(rd_pos_y_out),
        .rd_vel_x_out(rd_vel_x_out), .rd_vel_y_out(rd_vel_y_out),
        .begin_out(begin_out), .pos_x_out(pos_x_out), .pos_y_out(pos_y_out),
        .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
        .new_pos_x_in(new_pos_x_in), .new_pos_y_in(new_pos_y_in),
        .new_vel_x_in(new_vel_x_in), .new_vel_y_in(new_vel_y_in),
        .result_in(result_in), .busy_out(busy_out), .frame_done_out(frame_done_out),
        .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // Model state
    logic [7:0] mem_px [NP], mem_py [NP], mem_vx [NP], mem_vy [NP];
    bit         exp_begin [MAXC], exp_busy [MAXC], exp_done [MAXC], exp_pv [MAXC];
    logic [7:0] exp_px [MAXC], exp_py [MAXC], exp_vx [MAXC], exp_vy [MAXC];
    int         to_cycle = 1 << 30;
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    int         resp_lat = 1, silent_pt = -1;
    bit         spur_issue = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the timeline model, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk_in);
            cyc++;
            #1;
            if (cyc < MAXC) begin
                chk("begin_out", begin_out, exp_begin[cyc]);
                chk("busy_out", busy_out, exp_busy[cyc]);
                chk("frame_done_out", frame_done_out, exp_done[cyc]);
                chk("timeout_out", timeout_out, (cyc >= to_cycle));
                if (exp_pv[cyc]) begin
                    chk("pos_x_out", pos_x_out, exp_px[cyc]);
                    chk("pos_y_out", pos_y_out, exp_py[cyc]);
                    chk("vel_x_out", vel_x_out, exp_vx[cyc]);
                    chk("vel_y_out", vel_y_out, exp_vy[cyc]);
                end
            end
        end
    end

    // Responder: new pos = pos + vel, vel unchanged, result resp_lat cycles after begin.
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk_in);
            resp_v = 1'b0;
            spur_v = 1'b0;
            if (busy_out !== 1'b1) k = 0;
            if (begin_out === 1'b1) begin
                if (spur_issue) spur_v = 1'b1;
                if (k != silent_pt) begin
                    resp_px = pos_x_out + vel_x_out;
                    resp_py = pos_y_out + vel_y_out;
                    resp_vx = vel_x_out;
                    resp_vy = vel_y_out;
                    repeat (resp_lat) begin
                        @(negedge clk_in);
                        spur_v = 1'b0;
                    end
                    resp_v = 1'b1;
                end
                k++;
            end
        end
    end

    task automatic drive_load(input int i, input logic [7:0] px, py, vx, vy);
        load_valid_in = 1'b1;
        load_idx_in   = i[1:0];
        load_pos_x_in = px; load_pos_y_in = py; load_vel_x_in = vx; load_vel_y_in = vy;
        if (i < NP) begin
            mem_px[i] = px; mem_py[i] = py; mem_vx[i] = vx; mem_vy[i] = vy;
        end
    endtask

    task automatic load_point(input int i, input logic [7:0] px, py, vx, vy);
        drive_load(i, px, py, vx, vy);
        @(negedge clk_in);
        load_valid_in = 1'b0;
    endtask

    // Starts a frame at the current negedge and lays out its expected timeline.
    task automatic start_frame(input int lat, input int silent, input bit spur, output int t0);
        int t, lk;
        resp_lat = lat; silent_pt = silent; spur_issue = spur;
        frame_start_in = 1'b1;
        t0 = cyc;
        t  = t0 + 1;
        for (int k = 0; k < NP; k++) begin
            lk = (k == silent) ? TO : lat;
            exp_begin[t] = 1'b1;
            for (int c = t; c <= t + lk; c++) begin
                exp_busy[c] = 1'b1; exp_pv[c] = 1'b1;
                exp_px[c] = mem_px[k]; exp_py[c] = mem_py[k];
                exp_vx[c] = mem_vx[k]; exp_vy[c] = mem_vy[k];
            end
            if (k == silent) begin
                to_cycle = t + lk + 1;
            end else begin
                mem_px[k] = mem_px[k] + mem_vx[k];
                mem_py[k] = mem_py[k] + mem_vy[k];
            end
            t += lk + 1;
        end
        exp_done[t] = 1'b1;
        exp_busy[t] = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
        load_valid_in  = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int want);
        int d;
        d = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_in);
            if (frame_done_out === 1'b1) begin
                d = cyc;
                break;
            end
        end
        chk("frame_done_latency", d - t0, want);
        @(negedge clk_in);
    endtask

    task automatic check_rd(input int i, input logic [7:0] px, py, vx, vy);
        rd_idx_in = i[1:0];
        @(negedge clk_in);
        chk("rd_pos_x", rd_pos_x_out, px);
        chk("rd_pos_y", rd_pos_y_out, py);
        chk("rd_vel_x", rd_vel_x_out, vx);
        chk("rd_vel_y", rd_vel_y_out, vy);
    endtask

    task automatic check_rd_all();
        for (int i = 0; i < NP; i++) check_rd(i, mem_px[i], mem_py[i], mem_vx[i], mem_vy[i]);
    endtask

    task automatic do_reset();
        for (int c = cyc + 1; c < MAXC; c++) begin
            exp_begin[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_pv[c] = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            mem_px[i] = 8'h00; mem_py[i] = 8'h00; mem_vx[i] = 8'h00; mem_vy[i] = 8'h00;
        end
        to_cycle = 1 << 30;
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_begin", begin_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_done", frame_done_out, 1'b0);
        chk("rst_timeout", timeout_out, 1'b0);
        chk("rst_pos_out", {pos_x_out, pos_y_out, vel_x_out, vel_y_out}, 32'h0);
        chk("rst_rd_out", {rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out}, 32'h0);
        rst_in = 1'b0;
    endtask

    initial begin
        int t0;
        rst_in = 1'b1; frame_start_in = 1'b0; load_valid_in = 1'b0; load_idx_in = 2'd0;
        load_pos_x_in = 8'h00; load_pos_y_in = 8'h00; load_vel_x_in = 8'h00; load_vel_y_in = 8'h00;
        rd_idx_in = 2'd0;
        for (int i = 0; i < NP; i++) begin
            mem_px[i] = 8'h00; mem_py[i] = 8'h00; mem_vx[i] = 8'h00; mem_vy[i] = 8'h00;
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check_rd_all();

        // Load point 0 in the same cycle as frame start; L=3 wraps x to 0.
        drive_load(0, 8'd2, 8'd3, 8'hFE, 8'h00);
        start_frame(3, -1, 1'b0, t0);
        chk("first_begin", begin_out, 1'b1);
        wait_done(t0, 17);
        check_rd(0, 8'd0, 8'd3, 8'hFE, 8'h00);

        // Four loaded points, L=1.
        load_point(0, 8'd10, 8'd20, 8'd1, 8'd1);
        load_point(1, 8'd30, 8'd40, 8'd2, 8'd2);
        load_point(2, 8'd50, 8'd60, 8'd3, 8'd3);
        load_point(3, 8'd70, 8'd80, 8'd4, 8'd4);
        start_frame(1, -1, 1'b0, t0);
        wait_done(t0, 9);
        check_rd(0, 8'd11, 8'd21, 8'd1, 8'd1);
        check_rd(1, 8'd32, 8'd42, 8'd2, 8'd2);
        check_rd(2, 8'd53, 8'd63, 8'd3, 8'd3);
        check_rd(3, 8'd74, 8'd84, 8'd4, 8'd4);

        // frame_start and load while busy are dropped.
        start_frame(2, -1, 1'b0, t0);
        @(negedge clk_in);
        frame_start_in = 1'b1; load_valid_in = 1'b1; load_idx_in = 2'd1;
        load_pos_x_in = 8'h77; load_pos_y_in = 8'h77; load_vel_x_in = 8'h77; load_vel_y_in = 8'h77;
        @(negedge clk_in);
        frame_start_in = 1'b0; load_valid_in = 1'b0;
        wait_done(t0, 13);
        check_rd_all();

        // Spurious results in IDLE and in ISSUE leave the array alone.
        spur_idle_v = 1'b1;
        @(negedge clk_in);
        spur_idle_v = 1'b0;
        check_rd_all();
        start_frame(1, -1, 1'b1, t0);
        wait_done(t0, 9);
        spur_issue = 1'b0;
        check_rd_all();

        // Reset during WAIT of point 2 aborts the frame and clears the array.
        start_frame(3, -1, 1'b0, t0);
        while (cyc < t0 + 10) @(negedge clk_in);
        do_reset();
        repeat (4) @(negedge clk_in);
        check_rd_all();
        load_point(3, 8'd5, 8'd6, 8'd1, 8'd2);
        start_frame(1, -1, 1'b0, t0);
        wait_done(t0, 9);
        check_rd(3, 8'd6, 8'd8, 8'd1, 8'd2);
        check_rd_all();

`ifdef UPDATE_SEQ_TIMEOUT_EN
        // Silent responder on point 1: watchdog advances after TO WAIT cycles.
        load_point(1, 8'd9, 8'd9, 8'd1, 8'd1);
        start_frame(1, 1, 1'b0, t0);
        wait_done(t0, 16);
        chk("timeout_sticky", timeout_out, 1'b1);
        check_rd(1, 8'd9, 8'd9, 8'd1, 8'd1);
        check_rd_all();
`endif

        repeat (3) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/point_update_sequencer.md
Name: point_update_sequencer

Overview:
- Initiator side of the point-update handshake: holds the soft-body point state array and feeds each point in turn to a `update_point` responder.
- For each point: issues `begin_out` with that point's position/velocity, waits for `result_in`, then writes the returned new position/velocity back into the array.
- Sits between the frame-tick controller and the `update_point` instance. It owns point storage, so the render path reads points through its read port.

Parameters:
- POSITION_SIZE, 8, width of each position coordinate (unsigned).
- VELOCITY_SIZE, 8, width of each velocity component (two's complement).
- NUM_POINTS, 4, number of points in the array; legal range 1..256.
- IDX_W, $clog2(NUM_POINTS) with minimum 1, width of point index buses.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with UPDATE_SEQ_TIMEOUT_EN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- frame_start_in  in  1  single-cycle pulse: update every point once
- load_valid_in  in  1  write one point's initial state
- load_idx_in  in  IDX_W  point index for load
- load_pos_x_in, load_pos_y_in  in  POSITION_SIZE  initial position
- load_vel_x_in, load_vel_y_in  in  VELOCITY_SIZE  initial velocity
- rd_idx_in  in  IDX_W  readout index
- rd_pos_x_out, rd_pos_y_out  out  POSITION_SIZE  registered readout position
- rd_vel_x_out, rd_vel_y_out  out  VELOCITY_SIZE  registered readout velocity
- begin_out  out  1  one-cycle request pulse to responder
- pos_x_out, pos_y_out  out  POSITION_SIZE  current point position to responder
- vel_x_out, vel_y_out  out  VELOCITY_SIZE  current point velocity to responder
- new_pos_x_in, new_pos_y_in  in  POSITION_SIZE  responder result position
- new_vel_x_in, new_vel_y_in  in  VELOCITY_SIZE  responder result velocity
- result_in  in  1  responder result valid, one-cycle pulse
- busy_out  out  1  high from accept of frame_start_in until frame_done_out inclusive
- frame_done_out  out  1  one-cycle pulse after last point is written
- timeout_out  out  1  sticky watchdog flag

Behaviour:
- Reset:
  - FSM goes to IDLE, index to 0, every array entry to 0.
  - All outputs go to 0: begin_out, busy_out, frame_done_out, timeout_out, pos/vel outs and rd_* outs.
  - Reset mid-frame aborts the frame immediately; no frame_done_out is generated.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - frame_start_in moves to ISSUE with idx=0 and sets busy_out.
  - load_valid_in writes the load_* fields to entry load_idx_in; out-of-range indices are dropped.
  - If frame_start_in and load_valid_in arrive in the same cycle, the load is applied first and the frame sees the loaded value.
- ISSUE:
  - begin_out=1 for exactly this cycle.
  - pos/vel outs carry entry[idx]; they are held stable through WAIT.
  - Next state is WAIT.
- WAIT:
  - result_in is sampled only in WAIT, and only when result_in=1.
  - On result_in, new_* values are written to entry[idx].
  - If idx==NUM_POINTS-1, go to DONE; otherwise idx+1 and go to ISSUE.
  - result_in is ignored in every other state.
- DONE:
  - frame_done_out=1 for one cycle, busy_out still 1.
  - Next state is IDLE, where busy_out=0.
- Busy-time inputs: frame_start_in and load_valid_in are ignored whenever busy_out=1.
- Velocity handling: new_vel values are stored verbatim, with no saturation or sign handling in this block.
- Timing: frame_start_in sampled at cycle T gives begin_out at T+1. With responder latency L≥1 (result at begin+L):
  - point k issues at T+1+k(L+1);
  - frame_done_out at T+1+NUM_POINTS(L+1).
- Readout:
  - rd_* outputs equal entry[rd_idx_in] one cycle after sampling.
  - A write in cycle C is visible in a readout sampled at C+1.
  - Out-of-range rd_idx_in returns 0.

Optional Feature:
- Macro: UPDATE_SEQ_TIMEOUT_EN.
- Enabled:
  - Cycle counter clears on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES without result_in, entry[idx] is left unchanged and timeout_out is set.
  - The sequencer then advances exactly as on result_in (next point or DONE).
  - timeout_out clears only on reset.
- Disabled: WAIT holds indefinitely, timeout_out is tied 0, and no counter logic is built.

Test Plan:
- Load point 0 as (2,3,vel -2=8'hFE,0) with a responder returning pos+vel and vel unchanged at L=3 → begin_out at T+1, entry0 reads (0,3,8'hFE,0), frame_done_out at T+17 for NUM_POINTS=4.
- Four points loaded (10,20,1,1),(30,40,2,2),(50,60,3,3),(70,80,4,4), L=1 → begin_out at T+1,3,5,7; readback (11,21),(32,42),(53,63),(74,84); frame_done_out at T+9.
- frame_start_in and load_valid_in pulsed mid-frame → no restart, load dropped, frame_done_out count=1, target entry unchanged except by the update.
- Spurious result_in during IDLE and ISSUE → no array change; only the WAIT-cycle result is written.
- rst_in asserted during WAIT of point 2 → next cycle: all outputs 0, rd reads 0 for every index, no frame_done_out; a new frame after reset runs normally.
- With UPDATE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, responder silent on point 1 → timeout_out rises, entry1 unchanged, point 2 issues, frame_done_out still pulses once.
